multicycle_ctrl_seq: RTL
========================

Name: multicycle_ctrl_seq

Overview:
Parametrised successor to the core's multicycle control FSM.
- Sequences fetch / decode / execute / memory / writeback for the RV32 multicycle datapath.
- Replaces fixed-latency memory stages with ready handshakes and a timeout-to-fault watchdog.
- Adds pipeline stall, a retired-instruction counter and an optional resume from halt.
- Sits between the decoder's type flags and the datapath/memory enables.

Parameters:
STATE_W, 4, width of state output; must be >= 4.
TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before FAULT; 0 disables the watchdog.
RET_W, 32, width of retired_count.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
stall  input  1  hold in WAIT while high.
isSystype  input  1  decoded SYSTEM instruction.
isStype  input  1  decoded store.
isLtype  input  1  decoded load.
isJAL  input  1  decoded JAL.
isJALR  input  1  decoded JALR.
imem_ready  input  1  instruction memory data valid.
dmem_ready  input  1  data memory access complete.
resume  input  1  leave HLT (only with CTRL_RESUME_EN).
state  output  STATE_W  current state encoding.
fetch_req  output  1  high throughout FETCH.
dmem_req  output  1  high throughout MEM.
wb_en  output  1  register-file write strobe, high in WB.
retire  output  1  one-cycle pulse per completed instruction.
retired_count  output  RET_W  total retired instructions, wraps.
halted  output  1  high in HLT.
fault  output  1  high in FAULT.

Behaviour:
- State encodings: RESET=0, WAIT=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WB=6, HLT=7, FAULT=8.
- Outputs decode combinationally from state, except retire and retired_count.
- rst high, any time, asynchronous:
  - state=RESET; timeout counter and retired_count cleared.
  - All outputs 0.
  - Any in-flight access is abandoned.
- RESET -> WAIT unconditionally.
- WAIT -> FETCH when stall=0; else stay in WAIT.
- FETCH:
  - imem_ready=1 -> DECODE.
  - Else stay; timeout counter increments.
- DECODE:
  - isSystype=1 -> HLT.
  - Else -> EXECUTE.
- EXECUTE, priority order:
  - isLtype or isStype -> MEM.
  - Else -> WB (ALU, LUI/AUIPC, JAL, JALR all write back).
- MEM:
  - dmem_ready=1 and load -> WB.
  - dmem_ready=1 and store -> WAIT with retire.
  - Else stay; timeout counter increments.
  - Type flags are sampled from inputs; the decoder holds them stable until the next FETCH.
- WB -> WAIT with retire.
- HLT: terminal (see Optional Feature).
- FAULT: terminal until rst.
- Watchdog (TIMEOUT>0):
  - Counter is cleared on every entry to FETCH or MEM.
  - In FETCH/MEM with ready=0 and counter == TIMEOUT-1 -> FAULT.
  - Ready and timeout in the same cycle: ready wins.
  - Counter width is clog2(TIMEOUT+1).
- retire / retired_count:
  - retire is registered: it asserts in the cycle after the transition into WAIT from WB or MEM(store).
  - retired_count increments on the same edge that sets retire.
  - retired_count wraps from 2^RET_W-1 to 0.
  - The halting SYSTEM instruction is not counted.
- stall is ignored outside WAIT.
- Unused encodings (9..2^STATE_W-1) -> RESET on the next edge.

Optional Feature:
CTRL_RESUME_EN defined:
- HLT -> WAIT when resume=1; the SYSTEM instruction retires on that transition (retire pulse, count+1).
- resume is ignored in all other states.

CTRL_RESUME_EN undefined:
- HLT is terminal until rst.
- resume port is present but ignored.

Test Plan:
- ALU op, imem_ready immediate: rst released -> states RESET,WAIT,FETCH,DECODE,EXECUTE,WB,WAIT; retire pulses once; retired_count=1.
- Load with dmem_ready delayed 3 cycles: MEM held 4 cycles with dmem_req=1, then WB with wb_en=1; store with the same delay returns MEM->WAIT with wb_en never asserted; count +1 each.
- TIMEOUT=4, imem_ready held 0: FAULT entered after exactly 4 FETCH cycles; fault=1 until rst; imem_ready=1 on the 4th cycle gives DECODE instead.
- stall=1 for 5 cycles in WAIT: state stays 1; FETCH entered on the cycle after stall drops.
- SYSTEM instruction: HLT, halted=1; with CTRL_RESUME_EN, resume pulse -> WAIT and count+1; without it, state stays 7 for 20 cycles despite resume.
- RET_W=4, 16 ALU ops: retired_count wraps to 0; async rst asserted mid-MEM -> state=0 and dmem_req=0 before the next clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_seq_if.sv
// rtl/multicycle_ctrl_seq_if.sv - control/handshake bundle for the multicycle control sequencer
// Purpose: groups the decoder flags, memory handshakes and datapath enables.
// Ports (signals):
//   from master : stall, isSystype, isStype, isLtype, isJAL, isJALR,
//                 imem_ready, dmem_ready, resume
//   from slave  : state[STATE_W], fetch_req, dmem_req, wb_en, retire,
//                 retired_count[RET_W], halted, fault
// Modports: master (environment side), slave (sequencer side).
interface multicycle_ctrl_seq_if #(
  parameter int STATE_W = 4,
  parameter int RET_W   = 32
);
  logic               stall;
  logic               isSystype;
  logic               isStype;
  logic               isLtype;
  logic               isJAL;
  logic               isJALR;
  logic               imem_ready;
  logic               dmem_ready;
  logic               resume;
  logic [STATE_W-1:0] state;
  logic               fetch_req;
  logic               dmem_req;
  logic               wb_en;
  logic               retire;
  logic [RET_W-1:0]   retired_count;
  logic               halted;
  logic               fault;

  modport master (
    output stall, isSystype, isStype, isLtype, isJAL, isJALR,
           imem_ready, dmem_ready, resume,
    input  state, fetch_req, dmem_req, wb_en, retire, retired_count,
           halted, fault
  );

  modport slave (
    input  stall, isSystype, isStype, isLtype, isJAL, isJALR,
           imem_ready, dmem_ready, resume,
    output state, fetch_req, dmem_req, wb_en, retire, retired_count,
           halted, fault
  );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// rtl/multicycle_ctrl_seq.sv - multicycle RV32 control sequencer with ready handshakes and watchdog
// Purpose: steps fetch/decode/execute/memory/writeback, waits on imem/dmem ready
//   with a timeout-to-FAULT watchdog, counts retired instructions.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - multicycle_ctrl_seq_if.slave (decoder flags, handshakes, enables, status)
// Parameters: STATE_W (>=4), TIMEOUT (0 disables watchdog), RET_W.
// Option macro: CTRL_RESUME_EN - when defined, resume=1 leaves HLT and retires
//   the SYSTEM instruction; otherwise HLT is terminal until rst.
module multicycle_ctrl_seq #(
  parameter int STATE_W = 4,
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_ctrl_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_WAIT    = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXECUTE = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_HLT     = 4'd7,
    S_FAULT   = 4'd8
  } state_e;

  // A zero TIMEOUT still gets a 1-bit counter so the datapath stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             retire_q, retire_d;
  logic [RET_W-1:0] count_q;
  logic             timed_out;

  // Decoder distinguishes JAL/JALR, but both simply write back like ALU ops.
`ifdef CTRL_RESUME_EN
  logic unused_flags;
  assign unused_flags = bus.isJAL ^ bus.isJALR;
`else
  logic unused_flags;
  assign unused_flags = bus.isJAL ^ bus.isJALR ^ bus.resume;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RESET;
      wd_cnt_q <= '0;
      retire_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      retire_q <= retire_d;
      if (retire_d) begin
        count_q <= count_q + RET_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_d  = 1'b0;
    timed_out = (TIMEOUT > 0) && (wd_cnt_q == CNT_LAST);
    case (state_q)
      S_RESET:   state_d = S_WAIT;
      S_WAIT:    if (!bus.stall) state_d = S_FETCH;
      S_FETCH: begin
        // ready is checked first so a last-cycle response still proceeds
        if (bus.imem_ready)  state_d = S_DECODE;
        else if (timed_out)  state_d = S_FAULT;
      end
      S_DECODE:  state_d = bus.isSystype ? S_HLT : S_EXECUTE;
      S_EXECUTE: state_d = (bus.isLtype || bus.isStype) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (bus.isLtype) begin
            state_d = S_WB;
          end else begin
            state_d  = S_WAIT;
            retire_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        state_d  = S_WAIT;
        retire_d = 1'b1;
      end
      S_HLT: begin
`ifdef CTRL_RESUME_EN
        if (bus.resume) begin
          state_d  = S_WAIT;
          retire_d = 1'b1;
        end
`endif
      end
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_RESET;
    endcase

    // Counter runs only while lingering in a wait state; any entry clears it.
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end else begin
      wd_cnt_d = '0;
    end
  end

  assign bus.state         = STATE_W'(state_q);
  assign bus.fetch_req     = (state_q == S_FETCH);
  assign bus.dmem_req      = (state_q == S_MEM);
  assign bus.wb_en         = (state_q == S_WB);
  assign bus.halted        = (state_q == S_HLT);
  assign bus.fault         = (state_q == S_FAULT);
  assign bus.retire        = retire_q;
  assign bus.retired_count = count_q;

endmodule
